// File: rtl/atmega_io_bus_master.sv
// rtl/atmega_io_bus_master.sv - IO register bus initiator with READ/WRITE/SET/CLEAR/TOGGLE
//
// Purpose:
//   Takes one request at a time from a host on a valid/ready port and runs it
//   on the ATmega-style IO bus (addr/wr/rd/data). SET/CLEAR/TOGGLE are done as
//   an atomic read followed by a single write of the modified value. Exactly
//   one response is returned per request.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o  request handshake; req_op_i, req_addr_i, req_data_i
//                        (write data or bit mask) latched on accept
//   rsp_valid_o/ready_i  response handshake; rsp_data_o, rsp_err_o
//   addr_o, wr_o, rd_o   IO bus address and strobes (registered)
//   bus_o                IO bus write data (0 unless wr_o)
//   bus_i                IO bus read data, combinational from the slave
module atmega_io_bus_master #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int READ_WAIT_STATES  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [2:0]                   req_op_i,
  input  logic [BUS_ADDR_DATA_LEN-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]        req_data_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DATA_WIDTH-1:0]        rsp_data_o,
  output logic                         rsp_err_o,
  output logic [BUS_ADDR_DATA_LEN-1:0] addr_o,
  output logic                         wr_o,
  output logic                         rd_o,
  output logic [DATA_WIDTH-1:0]        bus_o,
  input  logic [DATA_WIDTH-1:0]        bus_i
);

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_SET   = 3'b010;
  localparam logic [2:0] OP_CLR   = 3'b011;
  localparam logic [2:0] OP_TGL   = 3'b100;

  localparam logic [3:0] WAIT_CNT = READ_WAIT_STATES[3:0];

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  state_t                         state_q, state_d;
  logic [2:0]                     op_q, op_d;
  logic [BUS_ADDR_DATA_LEN-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]          mask_q, mask_d;
  logic [3:0]                     cnt_q, cnt_d;
  logic                           rd_q, rd_d;
  logic                           wr_q, wr_d;
  logic [DATA_WIDTH-1:0]          bus_q, bus_d;
  logic                           rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]          rsp_data_q, rsp_data_d;
  logic                           rsp_err_q, rsp_err_d;
  logic                           ready_q, ready_d;

  function automatic logic [DATA_WIDTH-1:0] modify(input logic [2:0] op,
                                                   input logic [DATA_WIDTH-1:0] rdat,
                                                   input logic [DATA_WIDTH-1:0] m);
    case (op)
      OP_SET:  return rdat | m;
      OP_CLR:  return rdat & ~m;
      OP_TGL:  return rdat ^ m;
      default: return m;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    bus_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        // ready_q is only ever set while IDLE, so it also gates the first
        // cycle after reset release.
        if (req_valid_i && ready_q) begin
          op_d   = req_op_i;
          addr_d = req_addr_i;
          mask_d = req_data_i;
          case (req_op_i)
            OP_WRITE: begin
              state_d = S_WR;
              wr_d    = 1'b1;
              bus_d   = req_data_i;
            end
            OP_READ, OP_SET, OP_CLR, OP_TGL: begin
              state_d = S_RD;
              rd_d    = 1'b1;
              cnt_d   = '0;
            end
            default: begin
              state_d     = S_RSP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
            end
          endcase
        end
      end
      S_RD: begin
        if (cnt_q != WAIT_CNT) begin
          cnt_d = cnt_q + 4'd1;
          rd_d  = 1'b1;
        end else if (op_q == OP_READ) begin
          state_d     = S_RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus_i;
          rsp_err_d   = 1'b0;
        end else begin
          // Write value is computed from the live read data so the write
          // strobe follows the last read cycle directly.
          state_d = S_WR;
          wr_d    = 1'b1;
          bus_d   = modify(op_q, bus_i, mask_q);
        end
      end
      S_WR: begin
        state_d     = S_RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus_q;
        rsp_err_d   = 1'b0;
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          state_d    = S_IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      bus_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      bus_q       <= bus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign addr_o      = addr_q;
  assign rd_o        = rd_q;
  assign wr_o        = wr_q;
  assign bus_o       = bus_q;

endmodule

// File: tb/tb_atmega_io_bus_master.sv
// tb/tb_atmega_io_bus_master.sv - directed bench for atmega_io_bus_master (W=0 and W=2 instances)
module tb_atmega_io_bus_master;

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_SET   = 3'b010;
  localparam logic [2:0] OP_CLR   = 3'b011;
  localparam logic [2:0] OP_TGL   = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       req_valid [2];
  logic [2:0] req_op    [2];
  logic [7:0] req_addr  [2];
  logic [7:0] req_data  [2];
  logic       rsp_ready [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic       rsp_err   [2];
  logic [7:0] rsp_data  [2];
  logic [7:0] addr      [2];
  logic       wr        [2];
  logic       rd        [2];
  logic [7:0] bus_out   [2];
  logic [7:0] bus_in    [2];

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int total = 0;
  int bad   = 0;

  atmega_io_bus_master #(.BUS_ADDR_DATA_LEN(8), .DATA_WIDTH(8), .READ_WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_op_i(req_op[0]),
    .req_addr_i(req_addr[0]), .req_data_i(req_data[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
    .rsp_err_o(rsp_err[0]), .addr_o(addr[0]), .wr_o(wr[0]), .rd_o(rd[0]),
    .bus_o(bus_out[0]), .bus_i(bus_in[0])
  );

  atmega_io_bus_master #(.BUS_ADDR_DATA_LEN(8), .DATA_WIDTH(8), .READ_WAIT_STATES(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_op_i(req_op[1]),
    .req_addr_i(req_addr[1]), .req_data_i(req_data[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
    .rsp_err_o(rsp_err[1]), .addr_o(addr[1]), .wr_o(wr[1]), .rd_o(rd[1]),
    .bus_o(bus_out[1]), .bus_i(bus_in[1])
  );

  // IO slave models: registered write, combinational read
  always @(posedge clk) begin
    if (wr[0]) mem0[addr[0]] <= bus_out[0];
    if (wr[1]) mem1[addr[1]] <= bus_out[1];
  end
  assign bus_in[0] = rd[0] ? mem0[addr[0]] : 8'h00;
  assign bus_in[1] = rd[1] ? mem1[addr[1]] : 8'h00;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request on instance i with exact cycle-by-cycle checks of the bus
  // and response; hold = cycles rsp_ready stays low before the handshake.
  task automatic txn(input string tag, input int i, input logic [2:0] op,
                     input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] exp_bus, input logic [7:0] exp_rsp,
                     input logic exp_err, input int hold);
    int w;
    w = (i == 1) ? 2 : 0;
    chk({tag, ".ready_idle"}, 16'(req_ready[i]), 16'd1);
    req_valid[i] = 1'b1;
    req_op[i]    = op;
    req_addr[i]  = a;
    req_data[i]  = d;
    tick;
    req_valid[i] = 1'b0;
    req_op[i]    = 3'b111;
    req_addr[i]  = ~a;
    req_data[i]  = ~d;
    if (!exp_err) begin
      if (op != OP_WRITE) begin
        for (int k = 0; k <= w; k++) begin
          chk($sformatf("%s.rd%0d", tag, k), 16'(rd[i]), 16'd1);
          chk($sformatf("%s.rd%0d_wr", tag, k), 16'(wr[i]), 16'd0);
          chk($sformatf("%s.rd%0d_addr", tag, k), 16'(addr[i]), 16'(a));
          chk($sformatf("%s.rd%0d_bus", tag, k), 16'(bus_out[i]), 16'd0);
          chk($sformatf("%s.rd%0d_rspv", tag, k), 16'(rsp_valid[i]), 16'd0);
          chk($sformatf("%s.rd%0d_ready", tag, k), 16'(req_ready[i]), 16'd0);
          tick;
        end
      end
      if (op != OP_READ) begin
        chk({tag, ".wr"}, 16'(wr[i]), 16'd1);
        chk({tag, ".wr_rd"}, 16'(rd[i]), 16'd0);
        chk({tag, ".wr_addr"}, 16'(addr[i]), 16'(a));
        chk({tag, ".wr_bus"}, 16'(bus_out[i]), 16'(exp_bus));
        chk({tag, ".wr_rspv"}, 16'(rsp_valid[i]), 16'd0);
        tick;
      end
    end
    for (int k = 0; k <= hold; k++) begin
      chk($sformatf("%s.rsp%0d_valid", tag, k), 16'(rsp_valid[i]), 16'd1);
      chk($sformatf("%s.rsp%0d_data", tag, k), 16'(rsp_data[i]), 16'(exp_rsp));
      chk($sformatf("%s.rsp%0d_err", tag, k), 16'(rsp_err[i]), 16'(exp_err));
      chk($sformatf("%s.rsp%0d_strobes", tag, k), 16'({rd[i], wr[i]}), 16'd0);
      chk($sformatf("%s.rsp%0d_bus", tag, k), 16'(bus_out[i]), 16'd0);
      chk($sformatf("%s.rsp%0d_ready", tag, k), 16'(req_ready[i]), 16'd0);
      chk($sformatf("%s.rsp%0d_addr", tag, k), 16'(addr[i]), 16'(a));
      if (k == hold) rsp_ready[i] = 1'b1;
      tick;
    end
    rsp_ready[i] = 1'b0;
    chk({tag, ".done_rspv"}, 16'(rsp_valid[i]), 16'd0);
    chk({tag, ".done_ready"}, 16'(req_ready[i]), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_op[i]    = 3'b000;
      req_addr[i]  = 8'h00;
      req_data[i]  = 8'h00;
      rsp_ready[i] = 1'b0;
    end

    // 1: reset
    tick;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t1.rst%0d_ready", i), 16'(req_ready[i]), 16'd0);
      chk($sformatf("t1.rst%0d_rspv", i), 16'(rsp_valid[i]), 16'd0);
      chk($sformatf("t1.rst%0d_data", i), 16'(rsp_data[i]), 16'd0);
      chk($sformatf("t1.rst%0d_err", i), 16'(rsp_err[i]), 16'd0);
      chk($sformatf("t1.rst%0d_addr", i), 16'(addr[i]), 16'd0);
      chk($sformatf("t1.rst%0d_strobes", i), 16'({rd[i], wr[i]}), 16'd0);
      chk($sformatf("t1.rst%0d_bus", i), 16'(bus_out[i]), 16'd0);
    end
    tick;
    rst_n = 1'b1;
    chk("t1.ready_before_edge", 16'(req_ready[0]), 16'd0);
    tick;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t1.rel%0d_ready", i), 16'(req_ready[i]), 16'd1);
      chk($sformatf("t1.rel%0d_strobes", i), 16'({rd[i], wr[i]}), 16'd0);
    end

    // 2: plain write
    txn("t2.write", 0, OP_WRITE, 8'h23, 8'hA5, 8'hA5, 8'hA5, 1'b0, 0);
    chk("t2.slave", 16'(mem0[8'h23]), 16'h00A5);

    // 3: SET with W=0
    txn("t3.pre", 0, OP_WRITE, 8'h05, 8'h0F, 8'h0F, 8'h0F, 1'b0, 0);
    txn("t3.set", 0, OP_SET, 8'h05, 8'hF0, 8'hFF, 8'hFF, 1'b0, 0);
    chk("t3.slave", 16'(mem0[8'h05]), 16'h00FF);

    // 4: CLEAR / TOGGLE / READ with W=2
    txn("t4.pre1", 1, OP_WRITE, 8'h30, 8'hFF, 8'hFF, 8'hFF, 1'b0, 0);
    txn("t4.clr", 1, OP_CLR, 8'h30, 8'h81, 8'h7E, 8'h7E, 1'b0, 0);
    chk("t4.slave_clr", 16'(mem1[8'h30]), 16'h007E);
    txn("t4.pre2", 1, OP_WRITE, 8'h31, 8'h3C, 8'h3C, 8'h3C, 1'b0, 0);
    txn("t4.tgl", 1, OP_TGL, 8'h31, 8'h0F, 8'h33, 8'h33, 1'b0, 0);
    chk("t4.slave_tgl", 16'(mem1[8'h31]), 16'h0033);
    txn("t4.read", 1, OP_READ, 8'h31, 8'h00, 8'h00, 8'h33, 1'b0, 0);

    // 5: READ with response backpressure
    txn("t5.pre", 0, OP_WRITE, 8'h40, 8'h5A, 8'h5A, 8'h5A, 1'b0, 0);
    txn("t5.read", 0, OP_READ, 8'h40, 8'hFF, 8'h00, 8'h5A, 1'b0, 5);

    // 6: illegal ops, then reset during RD of a SET
    txn("t6.ill7", 0, 3'b111, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 0);
    txn("t6.ill5", 0, 3'b101, 8'h13, 8'h77, 8'h00, 8'h00, 1'b1, 2);
    txn("t6.pre", 0, OP_WRITE, 8'h10, 8'h0C, 8'h0C, 8'h0C, 1'b0, 0);
    req_valid[0] = 1'b1;
    req_op[0]    = OP_SET;
    req_addr[0]  = 8'h10;
    req_data[0]  = 8'hF0;
    tick;
    req_valid[0] = 1'b0;
    chk("t6.rst_rd_before", 16'(rd[0]), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t6.rst_strobes", 16'({rd[0], wr[0]}), 16'd0);
    chk("t6.rst_rspv", 16'(rsp_valid[0]), 16'd0);
    chk("t6.rst_ready", 16'(req_ready[0]), 16'd0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("t6.post%0d_strobes", k), 16'({rd[0], wr[0]}), 16'd0);
      chk($sformatf("t6.post%0d_rspv", k), 16'(rsp_valid[0]), 16'd0);
    end
    chk("t6.post_ready", 16'(req_ready[0]), 16'd1);
    chk("t6.slave_unchanged", 16'(mem0[8'h10]), 16'h000C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
